ex_stage_mc: RTL and testbench
==============================

Name: ex_stage_mc

Overview:
- Parametrised execute stage with a registered EX/MEM output and operand forwarding.
- Adds an iterative multi-cycle unit: unsigned multiply low word, divide quotient and divide remainder.
- Stalls ID while the multi-cycle unit runs.
- Sits between the ID/EX register and MEM. Single-cycle ops reuse the existing ALU block, driven by alu_sel.

Parameters:
- DW, 32, datapath width.
- IMM_W, 16, immediate width; sign-extended to DW.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  ID presents an instruction
- id_rs_data  in  DW  rs operand from register file
- id_rt_data  in  DW  rt operand from register file
- id_rt_imme_sel  in  1  0 = rt, 1 = sign-extended immediate on ALU src_b
- id_alu_sel  in  4  ALU function
- id_mc_op  in  2  00 none, 01 MUL, 10 DIVQ, 11 DIVR
- id_imme_i  in  IMM_W  immediate
- fwd_a  in  2  rs forward select: 00 rs, 01 MEM, 10 WB, 11 rs
- fwd_b  in  2  rt forward select, same encoding as fwd_a
- mem_fwd_data  in  DW  forwarded data from MEM
- wb_fwd_data  in  DW  forwarded data from WB
- id_rd  in  RD_W  destination register
- id_w_mem_ena  in  1  memory write enable
- id_w_reg_en  in  1  register write enable
- id_wb_sel  in  1  writeback select
- flush  in  1  kill the current instruction
- ex_stall  out  1  hold ID/EX
- ex_valid  out  1  EX/MEM register holds a valid instruction
- ex_alu_res  out  DW  result
- ex_rt_data  out  DW  forwarded rt value, used as store data
- ex_rd  out  RD_W  destination register
- ex_mem_en  out  1  memory write enable
- ex_w_reg_en  out  1  register write enable
- ex_wb_sel  out  1  writeback select
- ex_busy  out  1  multi-cycle unit in RUN

Behaviour:
- Forward muxes are fully combinational with no latches; select 11 behaves as 00.
- srcb_fwd feeds ex_rt_data. ALU src_b is srcb_fwd or the sign-extended immediate, chosen by id_rt_imme_sel.
- Reset: state IDLE, counter 0, all outputs 0.
- Accept condition: state == IDLE, id_valid = 1, flush = 0.
- Bubble: ex_valid, ex_mem_en and ex_w_reg_en are 0; data fields hold their previous values.
- FSM IDLE, accept with id_mc_op = 00:
  - Output register loads the ALU result and pass-through control at the next edge (latency 1).
  - ex_valid follows id_valid & ~flush; a non-accepted cycle loads a bubble.
- FSM IDLE, accept with id_mc_op != 00:
  - Latch srca_fwd, srcb_fwd, op, rd and control; set counter to DW; go to RUN.
  - Output register loads a bubble.
- FSM RUN:
  - ex_stall = 1 and ex_busy = 1; ID inputs and forward selects are ignored.
  - Each cycle performs one iteration and decrements the counter.
  - MUL: shift-add on a 2·DW accumulator; result is the low DW bits.
  - DIV: restoring divide, one quotient bit per cycle.
  - When counter reaches 1, the next edge loads the result with the latched control, sets ex_valid = 1 and returns to IDLE.
  - Total latency is DW+1 edges from accept to valid output.
- ex_stall = 1 only in RUN. In the cycle after the return to IDLE, ID presents the next instruction.
- Divide by zero: DIVQ returns all ones; DIVR returns the dividend; takes the same DW cycles.
- flush:
  - In IDLE, the output register loads a bubble.
  - In RUN, the operation is aborted, the FSM goes to IDLE at the next edge and a bubble is loaded.
  - flush wins over completion on the same edge.
- Asynchronous reset mid-RUN aborts immediately and clears all outputs.
- Back-to-back multi-cycle ops: the second is accepted the cycle after the first completes.

Optional Feature:
- Macro EX_SIGNED_MC_EN.
- Enabled:
  - Adds input port id_mc_signed (1 bit), latched at accept.
  - When set, operands are converted to magnitude before iteration and the result sign is corrected after it.
  - Quotient is truncated toward zero; the remainder takes the dividend's sign.
  - Most-negative / -1 returns quotient = most negative value, remainder = 0.
  - Signed divide by zero returns all ones / dividend.
  - Sign correction adds no extra cycle.
- Disabled: the port is absent and all multi-cycle ops are unsigned.

Test Plan:
- ALU path with forwarding: rs=5, fwd_a=01 with mem_fwd_data=7, immediate 0xFFFF selected, alu_sel=ADD -> ex_alu_res=6 one edge later, ex_valid=1.
- MUL 0x0001_0003 × 0x0000_0010 -> ex_alu_res=0x0010_0030 after 33 edges; ex_stall high for exactly 32 cycles; intermediate outputs are bubbles.
- DIVQ 100/7 -> 14; DIVR 100/7 -> 2; DIVQ 5/0 -> 0xFFFF_FFFF; DIVR 5/0 -> 5.
- flush asserted on RUN cycle 10 of a DIVQ -> FSM IDLE next edge, ex_valid=0, ex_stall=0, next ADD accepted normally.
- Reset pulse mid-MUL -> all outputs 0 immediately; after release, ADD 2+3 -> 5.
- With EX_SIGNED_MC_EN: DIVQ -7/2 -> -3, DIVR -> -1; MUL -3×4 -> 0xFFFF_FFF4; 0x8000_0000 / -1 -> 0x8000_0000, remainder 0.

Source files
------------

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: execute stage with rs/rt forwarding, a single-cycle ALU, a
// registered EX/MEM output and an iterative multi-cycle unit (MUL low word,
// divide quotient, divide remainder) that stalls ID while it runs.
// Optional build macro EX_SIGNED_MC_EN adds id_mc_signed for signed
// multi-cycle operations; without it every multi-cycle op is unsigned.
// ALU encoding (id_alu_sel): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR,
// 6 SLT (signed), 7 SLTU, 8 SLL a<<b, 9 SRL a>>b, A SRA a>>>b, B LUI b<<DW/2,
// others pass src_b.
module ex_stage_mc #(
    parameter int DW    = 32,
    parameter int IMM_W = 16,
    parameter int RD_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [DW-1:0]    id_rs_data,
    input  logic [DW-1:0]    id_rt_data,
    input  logic             id_rt_imme_sel,
    input  logic [3:0]       id_alu_sel,
    input  logic [1:0]       id_mc_op,
`ifdef EX_SIGNED_MC_EN
    input  logic             id_mc_signed,
`endif
    input  logic [IMM_W-1:0] id_imme_i,
    input  logic [1:0]       fwd_a,
    input  logic [1:0]       fwd_b,
    input  logic [DW-1:0]    mem_fwd_data,
    input  logic [DW-1:0]    wb_fwd_data,
    input  logic [RD_W-1:0]  id_rd,
    input  logic             id_w_mem_ena,
    input  logic             id_w_reg_en,
    input  logic             id_wb_sel,
    input  logic             flush,
    output logic             ex_stall,
    output logic             ex_valid,
    output logic [DW-1:0]    ex_alu_res,
    output logic [DW-1:0]    ex_rt_data,
    output logic [RD_W-1:0]  ex_rd,
    output logic             ex_mem_en,
    output logic             ex_w_reg_en,
    output logic             ex_wb_sel,
    output logic             ex_busy
);

    localparam int CW = $clog2(DW + 1);
    localparam int SW = $clog2(DW);

    localparam logic [1:0] MC_NONE = 2'b00;
    localparam logic [1:0] MC_MUL  = 2'b01;
    localparam logic [1:0] MC_DIVQ = 2'b10;
    localparam logic [1:0] MC_DIVR = 2'b11;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_NOR  = 4'h5;
    localparam logic [3:0] ALU_SLT  = 4'h6;
    localparam logic [3:0] ALU_SLTU = 4'h7;
    localparam logic [3:0] ALU_SLL  = 4'h8;
    localparam logic [3:0] ALU_SRL  = 4'h9;
    localparam logic [3:0] ALU_SRA  = 4'hA;
    localparam logic [3:0] ALU_LUI  = 4'hB;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    // Two's-complement negate when neg is set; used both to take magnitudes
    // before iteration and to restore the sign of the result afterwards.
    function automatic logic [DW-1:0] apply_sign(input logic [DW-1:0] val, input logic neg);
        return neg ? (~val + {{(DW-1){1'b0}}, 1'b1}) : val;
    endfunction

    // Control / FSM state
    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    // Multi-cycle datapath: acc holds {partial, multiplier} for MUL and
    // {remainder, quotient/dividend} for DIV; opb is multiplicand or divisor.
    logic [2*DW-1:0]   acc_q, acc_d;
    logic [DW-1:0]     opb_q, opb_d;
    logic [DW-1:0]     rt_q, rt_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              mem_en_q, mem_en_d;
    logic              w_reg_q, w_reg_d;
    logic              wb_sel_q, wb_sel_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              divz_q, divz_d;
    // EX/MEM output register
    logic              ex_valid_q, ex_valid_d;
    logic [DW-1:0]     ex_res_q, ex_res_d;
    logic [DW-1:0]     ex_rt_q, ex_rt_d;
    logic [RD_W-1:0]   ex_rd_q, ex_rd_d;
    logic              ex_mem_en_q, ex_mem_en_d;
    logic              ex_w_reg_q, ex_w_reg_d;
    logic              ex_wb_sel_q, ex_wb_sel_d;

    logic [DW-1:0]     srca_fwd, srcb_fwd;
    logic [DW-1:0]     imm_ext;
    logic [DW-1:0]     alu_a, alu_b, alu_res;
    logic signed [DW-1:0] alu_a_s, alu_b_s;
    logic              mc_sgn;
    logic [DW-1:0]     mag_a, mag_b;
    logic [DW:0]       mul_sum, div_shift, div_diff;
    logic              div_ge;
    logic [2*DW-1:0]   acc_step;
    logic [DW-1:0]     mc_res;
    logic              accept;

`ifdef EX_SIGNED_MC_EN
    assign mc_sgn = id_mc_signed;
`else
    assign mc_sgn = 1'b0;
`endif

    assign imm_ext = {{(DW-IMM_W){id_imme_i[IMM_W-1]}}, id_imme_i};
    assign alu_a   = srca_fwd;
    assign alu_b   = id_rt_imme_sel ? imm_ext : srcb_fwd;
    assign alu_a_s = alu_a;
    assign alu_b_s = alu_b;
    assign mag_a   = apply_sign(srca_fwd, mc_sgn & srca_fwd[DW-1]);
    assign mag_b   = apply_sign(srcb_fwd, mc_sgn & srcb_fwd[DW-1]);
    assign accept  = (state_q == S_IDLE) && id_valid && !flush;

    // Operand forwarding; select 11 falls back to the register-file value
    always_comb begin
        srca_fwd = id_rs_data;
        srcb_fwd = id_rt_data;
        case (fwd_a)
            2'b01:   srca_fwd = mem_fwd_data;
            2'b10:   srca_fwd = wb_fwd_data;
            default: srca_fwd = id_rs_data;
        endcase
        case (fwd_b)
            2'b01:   srcb_fwd = mem_fwd_data;
            2'b10:   srcb_fwd = wb_fwd_data;
            default: srcb_fwd = id_rt_data;
        endcase
    end

    // Single-cycle ALU
    always_comb begin
        alu_res = alu_b;
        case (id_alu_sel)
            ALU_ADD:  alu_res = alu_a + alu_b;
            ALU_SUB:  alu_res = alu_a - alu_b;
            ALU_AND:  alu_res = alu_a & alu_b;
            ALU_OR:   alu_res = alu_a | alu_b;
            ALU_XOR:  alu_res = alu_a ^ alu_b;
            ALU_NOR:  alu_res = ~(alu_a | alu_b);
            ALU_SLT:  alu_res = {{(DW-1){1'b0}}, (alu_a_s < alu_b_s)};
            ALU_SLTU: alu_res = {{(DW-1){1'b0}}, (alu_a < alu_b)};
            ALU_SLL:  alu_res = alu_a << alu_b[SW-1:0];
            ALU_SRL:  alu_res = alu_a >> alu_b[SW-1:0];
            ALU_SRA:  alu_res = $unsigned(alu_a_s >>> alu_b[SW-1:0]);
            ALU_LUI:  alu_res = alu_b << (DW / 2);
            default:  alu_res = alu_b;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*DW-1:DW]} + (acc_q[0] ? {1'b0, opb_q} : {(DW+1){1'b0}});
        div_shift = {acc_q[2*DW-1:DW], acc_q[DW-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_diff  = div_shift - {1'b0, opb_q};
        if (op_q == MC_MUL) begin
            acc_step = {mul_sum, acc_q[DW-1:1]};
        end else begin
            acc_step = {(div_ge ? div_diff[DW-1:0] : div_shift[DW-1:0]), acc_q[DW-2:0], div_ge};
        end
    end

    // Final result selection with sign correction folded into the last cycle
    always_comb begin
        mc_res = apply_sign(acc_step[DW-1:0], neg_q);
        if (op_q == MC_DIVR) begin
            mc_res = apply_sign(acc_step[2*DW-1:DW], rneg_q);
        end else if ((op_q == MC_DIVQ) && divz_q) begin
            mc_res = '1;
        end
    end

    // Next-state: FSM, multi-cycle latches and EX/MEM register
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        acc_d       = acc_q;
        opb_d       = opb_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        mem_en_d    = mem_en_q;
        w_reg_d     = w_reg_q;
        wb_sel_d    = wb_sel_q;
        neg_d       = neg_q;
        rneg_d      = rneg_q;
        divz_d      = divz_q;
        // Bubble by default: kill valid and write enables, hold data fields
        ex_valid_d  = 1'b0;
        ex_mem_en_d = 1'b0;
        ex_w_reg_d  = 1'b0;
        ex_res_d    = ex_res_q;
        ex_rt_d     = ex_rt_q;
        ex_rd_d     = ex_rd_q;
        ex_wb_sel_d = ex_wb_sel_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (id_mc_op == MC_NONE) begin
                        ex_valid_d  = 1'b1;
                        ex_res_d    = alu_res;
                        ex_rt_d     = srcb_fwd;
                        ex_rd_d     = id_rd;
                        ex_mem_en_d = id_w_mem_ena;
                        ex_w_reg_d  = id_w_reg_en;
                        ex_wb_sel_d = id_wb_sel;
                    end else begin
                        state_d  = S_RUN;
                        cnt_d    = CW'(DW);
                        op_d     = id_mc_op;
                        rt_d     = srcb_fwd;
                        rd_d     = id_rd;
                        mem_en_d = id_w_mem_ena;
                        w_reg_d  = id_w_reg_en;
                        wb_sel_d = id_wb_sel;
                        neg_d    = mc_sgn & (srca_fwd[DW-1] ^ srcb_fwd[DW-1]);
                        rneg_d   = mc_sgn & srca_fwd[DW-1];
                        divz_d   = (srcb_fwd == '0);
                        if (id_mc_op == MC_MUL) begin
                            acc_d = {{DW{1'b0}}, mag_b};
                            opb_d = mag_a;
                        end else begin
                            acc_d = {{DW{1'b0}}, mag_a};
                            opb_d = mag_b;
                        end
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d     = S_IDLE;
                        ex_valid_d  = 1'b1;
                        ex_res_d    = mc_res;
                        ex_rt_d     = rt_q;
                        ex_rd_d     = rd_q;
                        ex_mem_en_d = mem_en_q;
                        ex_w_reg_d  = w_reg_q;
                        ex_wb_sel_d = wb_sel_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
    end

    // State and registered outputs; async reset clears everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            op_q        <= MC_NONE;
            acc_q       <= '0;
            opb_q       <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            mem_en_q    <= 1'b0;
            w_reg_q     <= 1'b0;
            wb_sel_q    <= 1'b0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            divz_q      <= 1'b0;
            ex_valid_q  <= 1'b0;
            ex_res_q    <= '0;
            ex_rt_q     <= '0;
            ex_rd_q     <= '0;
            ex_mem_en_q <= 1'b0;
            ex_w_reg_q  <= 1'b0;
            ex_wb_sel_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            mem_en_q    <= mem_en_d;
            w_reg_q     <= w_reg_d;
            wb_sel_q    <= wb_sel_d;
            neg_q       <= neg_d;
            rneg_q      <= rneg_d;
            divz_q      <= divz_d;
            ex_valid_q  <= ex_valid_d;
            ex_res_q    <= ex_res_d;
            ex_rt_q     <= ex_rt_d;
            ex_rd_q     <= ex_rd_d;
            ex_mem_en_q <= ex_mem_en_d;
            ex_w_reg_q  <= ex_w_reg_d;
            ex_wb_sel_q <= ex_wb_sel_d;
        end
    end

    assign ex_stall    = busy_q;
    assign ex_busy     = busy_q;
    assign ex_valid    = ex_valid_q;
    assign ex_alu_res  = ex_res_q;
    assign ex_rt_data  = ex_rt_q;
    assign ex_rd       = ex_rd_q;
    assign ex_mem_en   = ex_mem_en_q;
    assign ex_w_reg_en = ex_w_reg_q;
    assign ex_wb_sel   = ex_wb_sel_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// tb_ex_stage_mc: directed and randomized checks of ex_stage_mc against a
// behavioural reference model (plain arithmetic on whole operands).
module tb_ex_stage_mc;

    localparam int DW = 32;
    localparam logic [1:0] MC_MUL  = 2'b01;
    localparam logic [1:0] MC_DIVQ = 2'b10;
    localparam logic [1:0] MC_DIVR = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        id_valid;
    logic [31:0] id_rs_data, id_rt_data;
    logic        id_rt_imme_sel;
    logic [3:0]  id_alu_sel;
    logic [1:0]  id_mc_op;
`ifdef EX_SIGNED_MC_EN
    logic        id_mc_signed;
`endif
    logic [15:0] id_imme_i;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic [4:0]  id_rd;
    logic        id_w_mem_ena, id_w_reg_en, id_wb_sel;
    logic        flush;
    logic        ex_stall, ex_valid, ex_busy;
    logic [31:0] ex_alu_res, ex_rt_data;
    logic [4:0]  ex_rd;
    logic        ex_mem_en, ex_w_reg_en, ex_wb_sel;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_res, last_rt;
    logic [4:0]  last_rd;
    logic        last_wb;

    ex_stage_mc #(.DW(32), .IMM_W(16), .RD_W(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rt_imme_sel(id_rt_imme_sel), .id_alu_sel(id_alu_sel),
        .id_mc_op(id_mc_op),
`ifdef EX_SIGNED_MC_EN
        .id_mc_signed(id_mc_signed),
`endif
        .id_imme_i(id_imme_i), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_fwd_data(mem_fwd_data), .wb_fwd_data(wb_fwd_data),
        .id_rd(id_rd), .id_w_mem_ena(id_w_mem_ena), .id_w_reg_en(id_w_reg_en),
        .id_wb_sel(id_wb_sel), .flush(flush),
        .ex_stall(ex_stall), .ex_valid(ex_valid), .ex_alu_res(ex_alu_res),
        .ex_rt_data(ex_rt_data), .ex_rd(ex_rd), .ex_mem_en(ex_mem_en),
        .ex_w_reg_en(ex_w_reg_en), .ex_wb_sel(ex_wb_sel), .ex_busy(ex_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd_ref(input logic [1:0] s, input logic [31:0] r,
                                            input logic [31:0] m, input logic [31:0] w);
        if (s == 2'd1) return m;
        if (s == 2'd2) return w;
        return r;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        case (s)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return ~(a | b);
            4'h6: return (sa < sb) ? 32'd1 : 32'd0;
            4'h7: return (a < b) ? 32'd1 : 32'd0;
            4'h8: return a << (b % 32);
            4'h9: return a >> (b % 32);
            4'hA: return 32'(sa >>> (b % 32));
            4'hB: return b * 32'h0001_0000;
            default: return b;
        endcase
    endfunction

    function automatic logic [31:0] mc_ref(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic sgn);
        longint unsigned p;
        int sa, sb;
        sa = a; sb = b;
        if (op == MC_MUL) begin
            p = longint'(a) * longint'(b);
            return p[31:0];
        end
        if (b == 32'd0) return (op == MC_DIVQ) ? 32'hFFFF_FFFF : a;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return (op == MC_DIVQ) ? 32'h8000_0000 : 32'd0;
            return (op == MC_DIVQ) ? 32'(sa / sb) : 32'(sa % sb);
        end
        return (op == MC_DIVQ) ? a / b : a % b;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic scramble();
        id_valid       = 1'($urandom_range(0, 1));
        id_rs_data     = $urandom;
        id_rt_data     = $urandom;
        id_rt_imme_sel = 1'($urandom_range(0, 1));
        id_alu_sel     = 4'($urandom_range(0, 15));
        id_mc_op       = 2'($urandom_range(0, 3));
        id_imme_i      = 16'($urandom);
        fwd_a          = 2'($urandom_range(0, 3));
        fwd_b          = 2'($urandom_range(0, 3));
        mem_fwd_data   = $urandom;
        wb_fwd_data    = $urandom;
        id_rd          = 5'($urandom_range(0, 31));
        id_w_mem_ena   = 1'($urandom_range(0, 1));
        id_w_reg_en    = 1'($urandom_range(0, 1));
        id_wb_sel      = 1'($urandom_range(0, 1));
`ifdef EX_SIGNED_MC_EN
        id_mc_signed   = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".valid"}, 32'(ex_valid), 32'd0);
        chk({tag, ".wen"}, 32'({ex_mem_en, ex_w_reg_en}), 32'd0);
        chk({tag, ".res_hold"}, ex_alu_res, last_res);
        chk({tag, ".rt_hold"}, ex_rt_data, last_rt);
        chk({tag, ".rd_hold"}, 32'(ex_rd), 32'(last_rd));
        chk({tag, ".stall"}, 32'(ex_stall), 32'd0);
    endtask

    task automatic run_alu(input string tag, input logic [3:0] sel, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [15:0] imm, input logic isel,
                           input logic [1:0] fa, input logic [1:0] fb,
                           input logic [31:0] memd, input logic [31:0] wbd);
        logic [31:0] a, b, bsrc, exp;
        logic [4:0]  rd;
        logic [2:0]  ctl;
        rd  = 5'($urandom_range(0, 31));
        ctl = 3'($urandom_range(0, 7));
        id_valid = 1'b1; flush = 1'b0; id_mc_op = 2'b00;
        id_alu_sel = sel; id_rs_data = rs; id_rt_data = rt; id_imme_i = imm;
        id_rt_imme_sel = isel; fwd_a = fa; fwd_b = fb;
        mem_fwd_data = memd; wb_fwd_data = wbd; id_rd = rd;
        {id_w_mem_ena, id_w_reg_en, id_wb_sel} = ctl;
        a    = fwd_ref(fa, rs, memd, wbd);
        b    = fwd_ref(fb, rt, memd, wbd);
        bsrc = isel ? {{16{imm[15]}}, imm} : b;
        exp  = alu_ref(sel, a, bsrc);
        @(negedge clk);
        id_valid = 1'b0;
        chk({tag, ".valid"}, 32'(ex_valid), 32'd1);
        chk({tag, ".res"}, ex_alu_res, exp);
        chk({tag, ".rt"}, ex_rt_data, b);
        chk({tag, ".rd"}, 32'(ex_rd), 32'(rd));
        chk({tag, ".ctl"}, 32'({ex_mem_en, ex_w_reg_en, ex_wb_sel}), 32'(ctl));
        last_res = exp; last_rt = b; last_rd = rd; last_wb = ctl[0];
    endtask

    // Presents a multi-cycle op, scrambles ID during RUN and checks the
    // bubbles, the stall length, the latency and the final result.
    task automatic run_mc(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic sgn, input logic [31:0] exp);
        logic [4:0] rd;
        logic [2:0] ctl;
        int lat, stalls, bad;
        rd  = 5'($urandom_range(0, 31));
        ctl = 3'($urandom_range(0, 7));
        id_valid = 1'b1; flush = 1'b0; id_mc_op = op;
        id_rs_data = $urandom; id_rt_data = $urandom;
        mem_fwd_data = $urandom; wb_fwd_data = $urandom;
        id_alu_sel = 4'($urandom_range(0, 15)); id_rt_imme_sel = 1'($urandom_range(0, 1));
        id_imme_i = 16'($urandom);
        case ($urandom_range(0, 2))
            0:       begin fwd_a = 2'b00; id_rs_data = a; end
            1:       begin fwd_a = 2'b01; mem_fwd_data = a; end
            default: begin fwd_a = 2'b11; id_rs_data = a; end
        endcase
        case ($urandom_range(0, 2))
            0:       begin fwd_b = 2'b00; id_rt_data = b; end
            1:       begin fwd_b = 2'b10; wb_fwd_data = b; end
            default: begin fwd_b = 2'b11; id_rt_data = b; end
        endcase
        id_rd = rd;
        {id_w_mem_ena, id_w_reg_en, id_wb_sel} = ctl;
`ifdef EX_SIGNED_MC_EN
        id_mc_signed = sgn;
`endif
        lat = 0; stalls = 0; bad = 0;
        for (int k = 1; k <= DW + 8 && lat == 0; k++) begin
            @(negedge clk);
            if (ex_valid) begin
                lat = k;
            end else begin
                if (ex_stall) stalls++;
                if (ex_mem_en || ex_w_reg_en || ex_alu_res !== last_res || ex_rd !== last_rd) bad++;
                scramble();
                flush = 1'b0;
            end
        end
        id_valid = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 32'(DW + 1));
        chk({tag, ".stall_cycles"}, 32'(stalls), 32'(DW));
        chk({tag, ".run_bubbles"}, 32'(bad), 32'd0);
        chk({tag, ".res"}, ex_alu_res, exp);
        chk({tag, ".model"}, ex_alu_res, mc_ref(op, a, b, sgn));
        chk({tag, ".rt"}, ex_rt_data, b);
        chk({tag, ".rd"}, 32'(ex_rd), 32'(rd));
        chk({tag, ".ctl"}, 32'({ex_mem_en, ex_w_reg_en, ex_wb_sel}), 32'(ctl));
        chk({tag, ".stall_end"}, 32'(ex_stall), 32'd0);
        last_res = ex_valid ? exp : last_res;
        last_rt = b; last_rd = rd; last_wb = ctl[0];
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rop;
        logic        rs_sgn;
        rst = 1'b1;
        scramble();
        id_valid = 1'b0; flush = 1'b0;
        last_res = '0; last_rt = '0; last_rd = '0; last_wb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset.valid", 32'(ex_valid), 32'd0);
        chk("reset.res", ex_alu_res, 32'd0);
        chk("reset.rt", ex_rt_data, 32'd0);
        chk("reset.rd", 32'(ex_rd), 32'd0);
        chk("reset.ctl", 32'({ex_mem_en, ex_w_reg_en, ex_wb_sel}), 32'd0);
        chk("reset.stall", 32'({ex_stall, ex_busy}), 32'd0);
        rst = 1'b0;

        // ALU path and forwarding
        run_alu("alu_fwd_imm", 4'h0, 32'd5, 32'd99, 16'hFFFF, 1'b1, 2'b01, 2'b00, 32'd7, 32'd1);
        chk("alu_fwd_imm.six", ex_alu_res, 32'd6);
        run_alu("alu_sub_wb", 4'h1, 32'd20, 32'd1, 16'h0, 1'b0, 2'b00, 2'b10, 32'd3, 32'd8);
        chk("alu_sub_wb.twelve", ex_alu_res, 32'd12);
        run_alu("alu_fwd11", 4'h3, 32'hF0F0_0000, 32'h0000_FF00, 16'h0, 1'b0, 2'b11, 2'b11,
                32'h1111_1111, 32'h2222_2222);
        chk("alu_fwd11.or", ex_alu_res, 32'hF0F0_FF00);
        run_alu("alu_slt", 4'h6, 32'hFFFF_FFFF, 32'd1, 16'h0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);

        // Idle bubbles: invalid instruction, then flush over a valid one
        scramble(); id_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk_bubble("bubble_invalid");
        scramble(); id_valid = 1'b1; id_mc_op = 2'b00; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; id_valid = 1'b0;
        chk_bubble("bubble_flush_idle");
        scramble(); id_valid = 1'b1; id_mc_op = MC_DIVQ; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; id_valid = 1'b0;
        chk_bubble("flush_mc_accept");

        // Multi-cycle ops, back to back
        run_mc("mul", MC_MUL, 32'h0001_0003, 32'h0000_0010, 1'b0, 32'h0010_0030);
        run_mc("divq", MC_DIVQ, 32'd100, 32'd7, 1'b0, 32'd14);
        run_mc("divr", MC_DIVR, 32'd100, 32'd7, 1'b0, 32'd2);
        run_mc("divq_zero", MC_DIVQ, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF);
        run_mc("divr_zero", MC_DIVR, 32'd5, 32'd0, 1'b0, 32'd5);
        run_mc("divq_big", MC_DIVQ, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF);

        // Flush on RUN cycle 10 of a DIVQ
        id_valid = 1'b1; flush = 1'b0; id_mc_op = MC_DIVQ;
        fwd_a = 2'b00; fwd_b = 2'b00; id_rs_data = 32'd1000; id_rt_data = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            id_valid = 1'b0;
        end
        chk("flush_run.stall_before", 32'(ex_stall), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk_bubble("flush_run");
        chk("flush_run.busy", 32'(ex_busy), 32'd0);
        run_alu("after_flush_add", 4'h0, 32'd40, 32'd2, 16'h0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);

        // Asynchronous reset in the middle of a MUL
        id_valid = 1'b1; id_mc_op = MC_MUL; fwd_a = 2'b00; fwd_b = 2'b00;
        id_rs_data = 32'd9; id_rt_data = 32'd9;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            id_valid = 1'b0;
        end
        chk("rst_mid.busy_before", 32'(ex_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid.valid", 32'(ex_valid), 32'd0);
        chk("rst_mid.res", ex_alu_res, 32'd0);
        chk("rst_mid.rt", ex_rt_data, 32'd0);
        chk("rst_mid.rd", 32'(ex_rd), 32'd0);
        chk("rst_mid.ctl", 32'({ex_mem_en, ex_w_reg_en, ex_wb_sel}), 32'd0);
        chk("rst_mid.stall", 32'({ex_stall, ex_busy}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_res = '0; last_rt = '0; last_rd = '0; last_wb = 1'b0;
        run_alu("after_rst_add", 4'h0, 32'd2, 32'd3, 16'h0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0);
        chk("after_rst_add.five", ex_alu_res, 32'd5);

`ifdef EX_SIGNED_MC_EN
        run_mc("s_divq", MC_DIVQ, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD);
        run_mc("s_divr", MC_DIVR, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF);
        run_mc("s_mul", MC_MUL, 32'hFFFF_FFFD, 32'd4, 1'b1, 32'hFFFF_FFF4);
        run_mc("s_ovf_q", MC_DIVQ, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000);
        run_mc("s_ovf_r", MC_DIVR, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0);
        run_mc("s_divq_zero", MC_DIVQ, 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF);
        run_mc("s_divr_zero", MC_DIVR, 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFF9);
`endif

        // Randomized mix against the reference model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: begin
                    run_alu("rand_alu", 4'($urandom_range(0, 15)), $urandom, $urandom,
                            16'($urandom), 1'($urandom_range(0, 1)),
                            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                            $urandom, $urandom);
                end
                5, 6, 7: begin
                    rop = 2'($urandom_range(1, 3));
                    ra  = $urandom;
                    rb  = ($urandom_range(0, 7) == 0) ? 32'd0 :
                          ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
                    rs_sgn = 1'b0;
`ifdef EX_SIGNED_MC_EN
                    rs_sgn = 1'($urandom_range(0, 1));
`endif
                    run_mc("rand_mc", rop, ra, rb, rs_sgn, mc_ref(rop, ra, rb, rs_sgn));
                end
                default: begin
                    scramble();
                    flush = ($urandom_range(0, 1) == 1);
                    if (!flush) id_valid = 1'b0;
                    @(negedge clk);
                    flush = 1'b0; id_valid = 1'b0;
                    chk_bubble("rand_bubble");
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
